// File: rtl/fixed_mult_pkg.sv
// Shared types and constants for the sequential fixed-point multiplier family.
package fixed_mult_pkg;

    // Handshake / iteration state of the multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Rounding mode selectors for ROUND_MODE.
    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_NEAREST = 1;

endpackage : fixed_mult_pkg

// File: rtl/fixed_round_sat.sv
// Combinational post-processing of an unsigned magnitude product:
// scale by FRAC, optional round-half-away-from-zero, apply sign,
// and either clamp or wrap on overflow.
module fixed_round_sat
    import fixed_mult_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 11,
    parameter int ROUND_MODE = ROUND_TRUNC,
    parameter int SATURATE   = 1
) (
    input  logic [2*WIDTH-1:0] i_p,
    input  logic               i_sign,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_ovf
);

    localparam int PW = 2 * WIDTH;
    localparam bit SAT_EN = (SATURATE != 0);

    logic             w_rnd_bit;
    logic [PW-1:0]    w_m;
    logic [PW-1:0]    w_limit;
    logic [WIDTH-1:0] w_neg;

    // The rounding bit is the first bit shifted out; it only exists when FRAC > 0.
    generate
        if ((ROUND_MODE == ROUND_NEAREST) && (FRAC > 0)) begin : g_round
            assign w_rnd_bit = i_p[FRAC-1];
        end else begin : g_trunc
            assign w_rnd_bit = 1'b0;
        end
    endgenerate

    // Rounding a magnitude up is "half away from zero" once the sign is applied.
    assign w_m = (i_p >> FRAC) + PW'(w_rnd_bit);

    // Negative results may reach one step further than positive ones.
    assign w_limit = i_sign ? (PW'(1) << (WIDTH - 1))
                            : ((PW'(1) << (WIDTH - 1)) - PW'(1));

    assign w_neg = ~w_m[WIDTH-1:0] + WIDTH'(1);

    // Select clamped, negated or plain magnitude as the final result.
    always_comb begin
        o_ovf    = (w_m > w_limit);
        o_result = {WIDTH{1'b0}};
        if (o_ovf && SAT_EN) begin
            o_result = i_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
        end else if (i_sign) begin
            o_result = w_neg;
        end else begin
            o_result = w_m[WIDTH-1:0];
        end
    end

endmodule : fixed_round_sat

// File: rtl/fixed_mult_seq.sv
// Signed fixed-point multiplier, one shift-and-add step per cycle over
// WIDTH cycles, with valid/ready handshakes on input and output.
module fixed_mult_seq
    import fixed_mult_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 11,
    parameter int ROUND_MODE = ROUND_TRUNC,
    parameter int SATURATE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sign;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_fin_result;
    logic             w_fin_ovf;

    // |-2^(W-1)| wraps back to 2^(W-1), which is exactly right read as unsigned.
    assign w_mag_a  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_mag_b  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept, WIDTH iterations, one finishing cycle, hand-off.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIN: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand capture, shift-and-add iteration and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_mcand  <= {PW{1'b0}};
            r_acc    <= {PW{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= {PW{1'b0}};
                        r_cnt    <= {CW{1'b0}};
                    end
                end
                CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                FIN: begin
                    r_result <= w_fin_result;
                    r_ovf    <= w_fin_ovf;
                end
                default: begin
                    r_result <= r_result;
                end
            endcase
        end
    end

    fixed_round_sat #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .ROUND_MODE (ROUND_MODE),
        .SATURATE   (SATURATE)
    ) u_round_sat (
        .i_p      (r_acc),
        .i_sign   (r_sign),
        .o_result (w_fin_result),
        .o_ovf    (w_fin_ovf)
    );

    assign result = r_result;
    assign ovf    = r_ovf;

endmodule : fixed_mult_seq

// File: tb/tb_fixed_mult_seq.sv
// Directed self-checking bench: three instances (truncate+saturate,
// truncate+wrap, round+saturate) driven in lockstep by one stimulus.
module tb_fixed_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        d_in_ready, d_out_valid, d_ovf;
    logic [15:0] d_result;
    logic        w_in_ready, w_out_valid, w_ovf;
    logic [15:0] w_result;
    logic        r_in_ready, r_out_valid, r_ovf;
    logic [15:0] r_result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fixed_mult_seq #(.WIDTH(16), .FRAC(11), .ROUND_MODE(0), .SATURATE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .a(a), .b(b), .out_valid(d_out_valid), .out_ready(out_ready),
        .result(d_result), .ovf(d_ovf));

    fixed_mult_seq #(.WIDTH(16), .FRAC(11), .ROUND_MODE(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .out_valid(w_out_valid), .out_ready(out_ready),
        .result(w_result), .ovf(w_ovf));

    fixed_mult_seq #(.WIDTH(16), .FRAC(11), .ROUND_MODE(1), .SATURATE(1)) u_rnd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
        .a(a), .b(b), .out_valid(r_out_valid), .out_ready(out_ready),
        .result(r_result), .ovf(r_ovf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; operands are scrambled after acceptance.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] ed, input logic ed_o,
                          input logic [15:0] ew, input logic ew_o,
                          input logic [15:0] er, input logic er_o,
                          input int hold);
        int cyc;
        logic both;
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, " in_ready"}, {31'd0, d_in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A;
        cyc = 0; both = 1'b0;
        while (!d_out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (d_in_ready && d_out_valid) both = 1'b1;
            if (cyc == 3) begin a = 16'h7FFF; b = 16'h8001; end
        end
        check({tag, " latency"}, cyc, 32'd17);
        check({tag, " valid_all"}, {29'd0, d_out_valid, w_out_valid, r_out_valid}, 32'd7);
        check({tag, " res_sat"}, {16'd0, d_result}, {16'd0, ed});
        check({tag, " ovf_sat"}, {31'd0, d_ovf}, {31'd0, ed_o});
        check({tag, " res_wrap"}, {16'd0, w_result}, {16'd0, ew});
        check({tag, " ovf_wrap"}, {31'd0, w_ovf}, {31'd0, ew_o});
        check({tag, " res_rnd"}, {16'd0, r_result}, {16'd0, er});
        check({tag, " ovf_rnd"}, {31'd0, r_ovf}, {31'd0, er_o});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, {31'd0, d_out_valid}, 32'd1);
            check({tag, " hold_in_ready"}, {31'd0, d_in_ready}, 32'd0);
            check({tag, " hold_res"}, {16'd0, d_result}, {16'd0, ed});
            check({tag, " hold_ovf"}, {31'd0, d_ovf}, {31'd0, ed_o});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " released"}, {30'd0, d_out_valid, d_in_ready}, 32'd1);
        check({tag, " no_overlap"}, {31'd0, both}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0000; b = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset in_ready", {31'd0, d_in_ready}, 32'd1);
        check("reset out_valid", {31'd0, d_out_valid}, 32'd0);
        check("reset result", {16'd0, d_result}, 32'd0);
        check("reset ovf", {31'd0, d_ovf}, 32'd0);
        rst_n = 1'b1;

        //            tag        a         b         sat          wrap         round        hold
        run_op("3x3",      16'h1800, 16'h1800, 16'h4800, 1'b0, 16'h4800, 1'b0, 16'h4800, 1'b0, 0);
        run_op("-3x3",     16'hE800, 16'h1800, 16'hB800, 1'b0, 16'hB800, 1'b0, 16'hB800, 1'b0, 0);
        run_op("-16x1",    16'h8000, 16'h0800, 16'h8000, 1'b0, 16'h8000, 1'b0, 16'h8000, 1'b0, 0);
        run_op("8x4",      16'h4000, 16'h2000, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 16'h7FFF, 1'b1, 0);
        run_op("minxmin",  16'h8000, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 16'h7FFF, 1'b1, 0);
        run_op("tiny_pos", 16'h0001, 16'h0400, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 0);
        run_op("tiny_neg", 16'hFFFF, 16'h0400, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 0);
        run_op("zero_neg", 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
        run_op("half_neg", 16'hFFFD, 16'h0400, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 0);
        run_op("neg_ovf",  16'hC000, 16'h2800, 16'h8000, 1'b1, 16'hC000, 1'b1, 16'h8000, 1'b1, 0);
        run_op("backpres", 16'h1800, 16'h1800, 16'h4800, 1'b0, 16'h4800, 1'b0, 16'h4800, 1'b0, 10);

        // Reset in the middle of CALC must discard the in-flight product.
        run_op("pre_rst",  16'h4000, 16'h2000, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 16'h7FFF, 1'b1, 0);
        @(negedge clk);
        a = 16'h1800; b = 16'h1800; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst in_ready", {31'd0, d_in_ready}, 32'd1);
        check("midrst out_valid", {31'd0, d_out_valid}, 32'd0);
        check("midrst result", {16'd0, d_result}, 32'd0);
        check("midrst ovf", {31'd0, d_ovf}, 32'd0);
        repeat (20) @(negedge clk);
        check("midrst discarded", {31'd0, d_out_valid}, 32'd0);
        run_op("post_rst", 16'hE800, 16'h1800, 16'hB800, 1'b0, 16'hB800, 1'b0, 16'hB800, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fixed_mult_seq
